uart_tx_core: RTL

// - Synthesizable UART transmitter: serializes bytes from a valid/ready stream onto one

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_tx_core.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: TX state encoding and the per-frame line configuration.
// Pure declarations; no latency or flow control of its own.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic two_stop;
    } uart_cfg_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: reloads on load/bit end and pulses bit_end_o for one cycle every div_i+1 enabled cycles.
// No backpressure; load_i takes priority and restarts the period.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_end_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign bit_end_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || bit_end_o) begin
            cnt_d = div_i;
        end else if (en_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte in, idle-high serial frame out; line changes 1 cycle after accept.
// Ready only in IDLE or the final cycle of the last stop bit, allowing zero-gap back-to-back frames.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             two_stop_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             tx_o,
    output logic             busy_o
);

    uart_tx_state_e   state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             stop_q, stop_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    uart_cfg_t        cfg_q, cfg_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             accept;

    assign busy_o     = (state_q != IDLE);
    assign tx_o       = tx_q;
    assign tx_ready_o = (state_q == IDLE) ||
                        ((state_q == STOP) && bit_end && (stop_q || !cfg_q.two_stop));
    assign accept     = tx_valid_i && tx_ready_o;

    // A frame accepted in the last stop cycle must time its start bit with the new divider.
    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept),
        .en_i      (busy_o),
        .div_i     (accept ? baud_div_i : div_q),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        data_d  = data_q;
        par_d   = par_q;
        cfg_d   = cfg_q;
        div_d   = div_q;
        tx_d    = 1'b1;

        case (state_q)
            IDLE: begin
                if (accept) state_d = START;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = cfg_q.parity_en ? PARITY : STOP;
                        stop_d  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!stop_q && cfg_q.two_stop) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = accept ? START : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d = tx_data_i;
            par_d  = (^tx_data_i) ^ parity_odd_i;
            cfg_d  = '{parity_en: parity_en_i, parity_odd: parity_odd_i, two_stop: two_stop_i};
            div_d  = baud_div_i;
        end

        // Line value is registered from the next state so tx_o has no combinational path.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            par_q   <= 1'b0;
            cfg_q   <= '0;
            div_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            par_q   <= par_d;
            cfg_q   <= cfg_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
        end
    end

endmodule
